// File: rtl/vtw_pattern_sequencer_if.sv
// vtw_pattern_sequencer_if
// Bundles the vector-memory write port, the start/stop control and the
// tester-cycle outputs of vtw_pattern_sequencer. Defining VTW_LOOP_EN adds
// the loop_begin/loop_end/loop_count signals.
//
// Handshake: start is a single-cycle request. It is taken only while the
// sequencer is idle. stop aborts a run while busy is high. done is a
// one-cycle pulse that ends every accepted start, whether the run completed
// or was aborted. There is no backpressure, and tester_sync qualifies
// wft/wfc on every active tester cycle.
interface vtw_pattern_sequencer_if #(
    parameter int INT_SIZE = 32,
    parameter int AW       = 6,
    parameter int RPT_W    = 8
);
    // Vector memory write port: {rpt, wft, wfc}
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [RPT_W+19:0]     mem_wdata;

    // Run control
    logic [AW-1:0]         last_addr;
    logic                  start;
    logic                  stop;

    // Status
    logic                  busy;
    logic                  done;

    // Tester-cycle stream toward the timing block
    logic                  tester_sync;
    logic [INT_SIZE-1:0]   vector_number;
    logic [INT_SIZE-1:0]   cycle_number;
    logic [3:0]            wft;
    logic [15:0]           wfc;

`ifdef VTW_LOOP_EN
    // Loop region, latched at start
    logic [AW-1:0]         loop_begin;
    logic [AW-1:0]         loop_end;
    logic [RPT_W-1:0]      loop_count;
`endif

    // Side that loads vectors and launches runs
    modport master (
`ifdef VTW_LOOP_EN
        output loop_begin, loop_end, loop_count,
`endif
        output mem_we, mem_addr, mem_wdata, last_addr, start, stop,
        input  busy, done, tester_sync, vector_number, cycle_number, wft, wfc
    );

    // Sequencer side
    modport slave (
`ifdef VTW_LOOP_EN
        input  loop_begin, loop_end, loop_count,
`endif
        input  mem_we, mem_addr, mem_wdata, last_addr, start, stop,
        output busy, done, tester_sync, vector_number, cycle_number, wft, wfc
    );
endinterface

// File: rtl/vtw_pattern_sequencer.sv
// vtw_pattern_sequencer
// Plays a preloaded list of test vectors onto the pattern timing block, one
// tester cycle per clock. Each memory word is {rpt, wft, wfc}. A vector
// occupies rpt+1 consecutive tester cycles. Playback runs from address 0
// through last_addr.
//
// Optional feature macro: VTW_LOOP_EN. When it is defined, the region
// loop_begin..loop_end is replayed loop_count extra times before playback
// continues linearly.
//
// Datapath: the memory has one registered read port. A prefetch register
// (pre_data/pre_addr) always holds the word that will play after the
// current vector. When the current vector reaches its final cycle, the
// prefetched word moves into the output registers and the next read is
// issued in the same cycle. Vectors and loop jumps therefore play
// back-to-back without bubbles.
module vtw_pattern_sequencer #(
    parameter int INT_SIZE = 32,
    parameter int AW       = 6,
    parameter int RPT_W    = 8
) (
    input  logic                       tester_clk,
    input  logic                       tester_reset,
    vtw_pattern_sequencer_if.slave     bus,
    output logic [1:0]                 state_dbg
);

    localparam int DW    = RPT_W + 20;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;

    // Vector storage; contents survive reset
    logic [DW-1:0]      mem [DEPTH];

    // Read port
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_q;

    // Prefetched word and the address it came from
    logic [DW-1:0]      pre_data;
    logic [AW-1:0]      pre_addr;
    logic               pre_jump;
    logic               pre_final;
    logic [AW-1:0]      pre_next;

    // Run bookkeeping for the vector currently on the outputs
    logic [AW-1:0]      last_q;
    logic [RPT_W-1:0]   rpt_cnt;
    logic               cur_final;
    logic               advance;
    logic               finish;
    logic               mem_wr_ok;

`ifdef VTW_LOOP_EN
    logic [AW-1:0]      lbeg_q;
    logic [AW-1:0]      lend_q;
    logic [RPT_W-1:0]   pass_q;
`endif

    assign state_dbg = state;
    assign pre_data  = rd_q;

    // The prefetched word decides what plays after it. A loop jump takes
    // precedence over ending, so a region that ends on last_addr still
    // completes all of its passes.
`ifdef VTW_LOOP_EN
    assign pre_jump = (pre_addr == lend_q) && (pass_q != '0);
    assign pre_next = pre_jump ? lbeg_q : pre_addr + AW'(1);
`else
    assign pre_jump = 1'b0;
    assign pre_next = pre_addr + AW'(1);
`endif
    assign pre_final = (pre_addr == last_q) && !pre_jump;

    // The run ends after the final cycle of the last vector, or on stop.
    // stop takes priority over a normal advance.
    assign finish = (state == S_RUN) &&
                    (bus.stop || ((rpt_cnt == '0) && cur_final));

    // Move the prefetched word onto the outputs: at FETCH exit, and in RUN
    // on the final cycle of any vector other than the last one.
    always_comb begin
        advance = 1'b0;
        if ((state == S_FETCH) && !bus.stop) begin
            advance = 1'b1;
        end else if ((state == S_RUN) && !bus.stop &&
                     (rpt_cnt == '0) && !cur_final) begin
            advance = 1'b1;
        end
    end

    // Read address selection. A start reads vector 0, and each advance
    // reads the word that follows the one being consumed.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if ((state == S_IDLE) && bus.start) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (advance) begin
            rd_en   = 1'b1;
            rd_addr = pre_next;
        end
    end

    // Memory writes are taken only while not busy (IDLE or DONE)
    assign mem_wr_ok = bus.mem_we && ((state == S_IDLE) || (state == S_DONE));

    // Vector memory write port
    always_ff @(posedge tester_clk) begin
        if (mem_wr_ok) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Vector memory registered read port
    always_ff @(posedge tester_clk) begin
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Sequencer FSM, with registered tester-cycle outputs and status
    always_ff @(posedge tester_clk) begin
        if (tester_reset) begin
            state             <= S_IDLE;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.tester_sync   <= 1'b0;
            bus.vector_number <= '0;
            bus.cycle_number  <= '0;
            bus.wft           <= '0;
            bus.wfc           <= '0;
            rpt_cnt           <= '0;
            cur_final         <= 1'b0;
            pre_addr          <= '0;
            last_q            <= '0;
`ifdef VTW_LOOP_EN
            lbeg_q            <= '0;
            lend_q            <= '0;
            pass_q            <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start wins over a stop in the same cycle
                    if (bus.start) begin
                        state             <= S_FETCH;
                        bus.busy          <= 1'b1;
                        bus.vector_number <= '0;
                        bus.cycle_number  <= '0;
                        last_q            <= bus.last_addr;
                        pre_addr          <= '0;
`ifdef VTW_LOOP_EN
                        lbeg_q            <= bus.loop_begin;
                        lend_q            <= bus.loop_end;
                        pass_q            <= bus.loop_count;
`endif
                    end
                end

                S_FETCH: begin
                    if (bus.stop) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (finish) begin
                        state           <= S_DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.tester_sync <= 1'b0;
                    end else begin
                        bus.cycle_number <= bus.cycle_number + INT_SIZE'(1);
                        if (rpt_cnt == '0) begin
                            bus.vector_number <= bus.vector_number + INT_SIZE'(1);
                        end else begin
                            rpt_cnt <= rpt_cnt - RPT_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Load the prefetched vector onto the outputs. This shares the
            // cycle with the FETCH->RUN step or with a RUN vector boundary.
            if (advance) begin
                bus.tester_sync <= 1'b1;
                bus.wft         <= pre_data[19:16];
                bus.wfc         <= pre_data[15:0];
                rpt_cnt         <= pre_data[DW-1:20];
                cur_final       <= pre_final;
                pre_addr        <= pre_next;
`ifdef VTW_LOOP_EN
                if (pre_jump) begin
                    pass_q <= pass_q - RPT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vtw_pattern_sequencer.sv
// tb_vtw_pattern_sequencer
// Directed and randomized playback runs of vtw_pattern_sequencer. A
// reference model expands the stored vectors into one expected entry per
// tester cycle. Each expected entry holds the vector_number, wft and wfc
// for that cycle, and cycle_number must equal the entry's position. Loop
// cases are compiled only when VTW_LOOP_EN is defined.
module tb_vtw_pattern_sequencer;

    localparam int INT_SIZE = 32;
    localparam int AW       = 6;
    localparam int RPT_W    = 8;
    localparam int DW       = RPT_W + 20;
    localparam int DEPTH    = 1 << AW;

    // Clock and reset
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    vtw_pattern_sequencer_if #(.INT_SIZE(INT_SIZE), .AW(AW), .RPT_W(RPT_W)) bus ();

    vtw_pattern_sequencer #(.INT_SIZE(INT_SIZE), .AW(AW), .RPT_W(RPT_W)) dut (
        .tester_clk   (clk),
        .tester_reset (rst),
        .bus          (bus),
        .state_dbg    (state_dbg)
    );

    // Scoreboard
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] tb_mem [DEPTH];
    logic [51:0]   exp_q[$];          // {vector_number[31:0], wft, wfc}
    bit            loop_on   = 1'b0;
    int            lp_begin  = 0;
    int            lp_end    = 0;
    int            lp_count  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_vec(input int a, input int rpt, input logic [3:0] w_t, input logic [15:0] w_c);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = AW'(a);
        bus.mem_wdata = {RPT_W'(rpt), w_t, w_c};
        tb_mem[a]     = {RPT_W'(rpt), w_t, w_c};
        tick();
        bus.mem_we    = 1'b0;
    endtask

    // Reference model: follow the address order and expand each vector
    // into rpt+1 cycles. Truncate the list when a stop is planned.
    task automatic build_model(input int last, input int stop_at);
        int            a;
        int            passes;
        int            vn;
        logic [DW-1:0] d;
        exp_q.delete();
        a      = 0;
        passes = lp_count;
        vn     = 0;
        for (int guard = 0; guard < 4096; guard++) begin
            d = tb_mem[a];
            for (int r = 0; r <= int'(d[DW-1:20]); r++) begin
                exp_q.push_back({32'(vn), d[19:0]});
            end
            vn++;
            if (loop_on && (a == lp_end) && (passes > 0)) begin
                a = lp_begin;
                passes--;
            end else if (a == last) begin
                break;
            end else begin
                a = (a + 1) % DEPTH;
            end
        end
        if (stop_at >= 0) begin
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
        end
    endtask

    // Driver and checker for one run. stop_at>0 raises stop during that
    // RUN cycle (1-based). poke drives start and mem_we mid-run.
    // with_stop raises stop together with start.
    task automatic run_pattern(input string tag, input int last, input int stop_at,
                               input bit poke, input bit with_stop, output int played);
        bit          finished;
        logic [51:0] e;
        logic [51:0] last_e;
        int          idx;
        build_model(last, stop_at);
        bus.last_addr = AW'(last);
`ifdef VTW_LOOP_EN
        bus.loop_begin = AW'(lp_begin);
        bus.loop_end   = AW'(lp_end);
        bus.loop_count = RPT_W'(lp_count);
`endif
        bus.start = 1'b1;
        bus.stop  = with_stop;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk({tag, "_fetch_busy"}, bus.busy, 1);
        chk({tag, "_fetch_sync"}, bus.tester_sync, 0);
        idx      = 0;
        finished = 1'b0;
        last_e   = '0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            tick();
            bus.stop   = 1'b0;
            bus.start  = 1'b0;
            bus.mem_we = 1'b0;
            if (bus.done) begin
                finished = 1'b1;
            end else begin
                chk({tag, "_sync"}, bus.tester_sync, 1);
                chk({tag, "_busy"}, bus.busy, 1);
                if (idx < exp_q.size()) begin
                    e = exp_q[idx];
                    chk({tag, "_vn"},  bus.vector_number, e[51:20]);
                    chk({tag, "_wft"}, bus.wft, e[19:16]);
                    chk({tag, "_wfc"}, bus.wfc, e[15:0]);
                    chk({tag, "_cn"},  bus.cycle_number, idx);
                    last_e = e;
                end else begin
                    chk({tag, "_overrun"}, idx + 1, exp_q.size());
                end
                idx++;
                if (idx == stop_at) bus.stop = 1'b1;
                if (poke && idx == 2) begin
                    bus.start     = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = AW'(1);
                    bus.mem_wdata = DW'($urandom);
                end
            end
        end
        played = idx;
        chk({tag, "_done_seen"}, finished, 1);
        chk({tag, "_len"}, idx, exp_q.size());
        chk({tag, "_done_sync"}, bus.tester_sync, 0);
        chk({tag, "_done_busy"}, bus.busy, 0);
        chk({tag, "_hold_vn"},  bus.vector_number, last_e[51:20]);
        chk({tag, "_hold_wfc"}, bus.wfc, last_e[15:0]);
        chk({tag, "_hold_cn"},  bus.cycle_number, idx - 1);
        tick();
        chk({tag, "_done_once"}, bus.done, 0);
        chk({tag, "_idle_sync"}, bus.tester_sync, 0);
        chk({tag, "_idle_wft"},  bus.wft, last_e[19:16]);
    endtask

    // Start a run, then apply reset after run_cycles RUN cycles
    task automatic run_reset(input int last, input int run_cycles);
        bus.last_addr = AW'(last);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (1 + run_cycles) tick();
        chk("rstmid_running", bus.tester_sync, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_done", bus.done, 0);
        chk("rstmid_sync", bus.tester_sync, 0);
        chk("rstmid_vn",   bus.vector_number, 0);
        chk("rstmid_cn",   bus.cycle_number, 0);
        chk("rstmid_wft",  bus.wft, 0);
        chk("rstmid_wfc",  bus.wfc, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rstmid_no_done", bus.done, 0);
            chk("rstmid_no_sync", bus.tester_sync, 0);
        end
    endtask

    // Directed sequence followed by randomized runs
    initial begin
        int played;
        int last;
        int total;
        int stop_at;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.last_addr = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
`ifdef VTW_LOOP_EN
        bus.loop_begin = '0;
        bus.loop_end   = '0;
        bus.loop_count = '0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_sync", bus.tester_sync, 0);
        chk("reset_vn",   bus.vector_number, 0);
        chk("reset_cn",   bus.cycle_number, 0);
        chk("reset_wft",  bus.wft, 0);
        chk("reset_wfc",  bus.wfc, 0);
        rst = 1'b0;
        tick();

        // Linear play: rpt 0,2,1 -> 6 cycles, vector_number 0,1,1,1,2,2
        for (int i = 0; i < 3; i++) begin
            wr_vec(i, (i == 0) ? 0 : ((i == 1) ? 2 : 1), 4'($urandom), {8'($urandom), 8'(i)});
        end
        run_pattern("linear", 2, -1, 1'b0, 1'b0, played);
        chk("linear_cycles", played, 6);

        // Ignored start and mem_we while busy; a rerun confirms memory is intact
        run_pattern("ignored", 2, -1, 1'b1, 1'b0, played);
        chk("ignored_cycles", played, 6);
        run_pattern("ignored_replay", 2, -1, 1'b0, 1'b0, played);

        // start together with stop in IDLE: start wins
        run_pattern("start_stop", 2, -1, 1'b0, 1'b1, played);
        chk("start_stop_cycles", played, 6);

        // No bubbles: four single-cycle vectors
        for (int i = 0; i < 4; i++) begin
            wr_vec(i, 0, 4'($urandom), {8'($urandom), 8'(i + 16)});
        end
        run_pattern("nobubble", 3, -1, 1'b0, 1'b0, played);
        chk("nobubble_cycles", played, 4);

        // last_addr=0 plays only vector 0
        run_pattern("last0", 0, -1, 1'b0, 1'b0, played);
        chk("last0_cycles", played, 1);

        // Abort in the 3rd RUN cycle of a 10-cycle pattern
        wr_vec(0, 4, 4'h3, 16'hA0A0);
        wr_vec(1, 4, 4'h5, 16'hB1B1);
        run_pattern("abort", 1, 3, 1'b0, 1'b0, played);
        chk("abort_cycles", played, 3);

        // Reset mid-run, then the restart replays the same memory
        run_reset(1, 4);
        run_pattern("after_reset", 1, -1, 1'b0, 1'b0, played);
        chk("after_reset_cycles", played, 10);

`ifdef VTW_LOOP_EN
        // Loop region 1..2 with two extra passes: 0,1,2,1,2,1,2,3
        for (int i = 0; i < 4; i++) begin
            wr_vec(i, 0, 4'(i), {8'($urandom), 8'(i + 32)});
        end
        loop_on  = 1'b1;
        lp_begin = 1;
        lp_end   = 2;
        lp_count = 2;
        run_pattern("loop", 3, -1, 1'b0, 1'b0, played);
        chk("loop_cycles", played, 8);
        chk("loop_vn_end", bus.vector_number, 7);
        lp_count = 0;
        run_pattern("loop_off", 3, -1, 1'b0, 1'b0, played);
        chk("loop_off_cycles", played, 4);
`endif

        // Randomized memories, lengths, stops and (if built) loop regions
        for (int t = 0; t < 6; t++) begin
            last = $urandom_range(1, 12);
            for (int i = 0; i <= last; i++) begin
                wr_vec(i, $urandom_range(0, 4), 4'($urandom), 16'($urandom));
            end
`ifdef VTW_LOOP_EN
            lp_end   = $urandom_range(0, last);
            lp_begin = $urandom_range(0, lp_end);
            lp_count = $urandom_range(0, 3);
`endif
            build_model(last, -1);
            total   = exp_q.size();
            stop_at = -1;
            if (total > 2 && $urandom_range(0, 2) == 0) stop_at = $urandom_range(1, total - 1);
            run_pattern($sformatf("rand%0d", t), last, stop_at, 1'b0, 1'b0, played);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
